cam_search_arb: RTL and testbench

Shares the single CAM search port between NUM_REQ tag-lookup requesters in the FIX parser using round-robin arbitration. Each search is confined to the current message window, the start/end addresses that the CAM write controller captures. The block sequences each search as issue, wait for CAM latency, then respond. It returns hit, index and requester ID to the winner.

---
 rtl/cam_search_arb_pkg.sv | 12 +
 rtl/cam_search_arb_if.sv | 45 ++++
 rtl/cam_search_arb_rr_arbiter.sv | 15 +
 rtl/cam_search_arb.sv | 113 +++++++++++
 tb/tb_cam_search_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_search_arb_pkg.sv
// cam_pkg: shared FSM state type, window-membership helper and widths for cam_search_arb
package cam_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} cam_arb_state_e;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W = $clog2(NUM_REQ_DEF);
  localparam int STATS_W = 16;
  localparam int AW_MAX = 16;
  // a window with s > e wraps past the top of the CAM
  function automatic logic in_window(logic [AW_MAX-1:0] idx, logic [AW_MAX-1:0] s, logic [AW_MAX-1:0] e);
    return (s <= e) ? (idx >= s && idx <= e) : (idx >= s || idx <= e);
  endfunction
endpackage

// File: rtl/cam_search_arb_if.sv
// cam_search_arb_if: requester, window, CAM and response signals; stats ports exist with SEARCH_STATS_EN
interface cam_search_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ = 4
) ();
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic win_valid_i;
  logic [ADDR_WIDTH-1:0] win_start_i;
  logic [ADDR_WIDTH-1:0] win_end_i;
  logic cam_search_o;
  logic [DATA_WIDTH-1:0] cam_search_data_o;
  logic [ADDR_WIDTH-1:0] cam_start_o;
  logic [ADDR_WIDTH-1:0] cam_end_o;
  logic cam_search_valid_i;
  logic [ADDR_WIDTH-1:0] cam_search_index_i;
  logic rsp_valid_o;
  logic [IW-1:0] rsp_id_o;
  logic rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_index_o;
  logic busy_o;
`ifdef SEARCH_STATS_EN
  logic [cam_pkg::STATS_W-1:0] hit_cnt_o;
  logic [cam_pkg::STATS_W-1:0] miss_cnt_o;
`endif
  modport master (
`ifdef SEARCH_STATS_EN
    input hit_cnt_o, miss_cnt_o,
`endif
    output req_valid_i, req_data_i, win_valid_i, win_start_i, win_end_i, cam_search_valid_i, cam_search_index_i,
    input req_ready_o, cam_search_o, cam_search_data_o, cam_start_o, cam_end_o,
    input rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_index_o, busy_o
  );
  modport slave (
`ifdef SEARCH_STATS_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    input req_valid_i, req_data_i, win_valid_i, win_start_i, win_end_i, cam_search_valid_i, cam_search_index_i,
    output req_ready_o, cam_search_o, cam_search_data_o, cam_start_o, cam_end_o,
    output rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_index_o, busy_o
  );
endinterface

// File: rtl/cam_search_arb_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or above i_ptr, wrapping modulo N
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);
  logic [N-1:0] w_rot, w_one;
  // rotate so i_ptr lands on bit 0, isolate the lowest set bit, rotate back
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign w_one = w_rot & (~w_rot + N'(1));
  assign o_gnt = N'({w_one, w_one} << i_ptr >> N);
endmodule

// File: rtl/cam_search_arb.sv
// cam_search_arb: round-robin sharing of one CAM search port, each search confined to the message window.
// Define SEARCH_STATS_EN to add saturating hit/miss counters.
module cam_search_arb import cam_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ = 4,
  parameter int CAM_LAT = 1
) (
  input logic clk,
  input logic rst,
  cam_search_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CAM_LAT + 1);
  cam_arb_state_e r_state, w_next;
  logic [IW-1:0] r_ptr, r_id, w_id;
  logic r_win_v, r_hit;
  logic [ADDR_WIDTH-1:0] r_win_s, r_win_e, r_snap_s, r_snap_e, r_idx;
  logic [DATA_WIDTH-1:0] r_key;
  logic [CW-1:0] r_cnt;
  logic [NUM_REQ-1:0] w_gnt, w_ready;
  logic w_grant, w_sample, w_hit;

  rr_arbiter #(.N(NUM_REQ)) u_arb (.i_req(bus.req_valid_i), .i_ptr(r_ptr), .o_gnt(w_gnt));

  assign w_grant = (r_state == IDLE) && r_win_v && (|bus.req_valid_i) && !rst;
  assign w_sample = (r_state == WAIT) && (r_cnt == CW'(CAM_LAT - 1));
  assign w_hit = bus.cam_search_valid_i &&
                 in_window(AW_MAX'(bus.cam_search_index_i), AW_MAX'(r_snap_s), AW_MAX'(r_snap_e));

  always_comb begin
    w_id = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_gnt[i]) w_id = IW'(i);
  end

  always_comb begin
    w_next = r_state;
    w_ready = '0;
    w_ready = w_grant ? w_gnt : '0;
    w_next = (r_state == IDLE)  ? (w_grant ? ISSUE : IDLE) :
             (r_state == ISSUE) ? WAIT :
             (r_state == WAIT)  ? (w_sample ? RESP : WAIT) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_win_v <= 1'b0;
      r_win_s <= '0;
      r_win_e <= '0;
      r_snap_s <= '0;
      r_snap_e <= '0;
      r_key <= '0;
      r_id <= '0;
      r_cnt <= '0;
      r_hit <= 1'b0;
      r_idx <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
      if (bus.win_valid_i) begin
        r_win_v <= 1'b1;
        r_win_s <= bus.win_start_i;
        r_win_e <= bus.win_end_i;
      end
      // the search keeps the window it was granted with, even if a new one loads mid-flight
      if (w_grant) begin
        r_key <= bus.req_data_i[w_id*DATA_WIDTH +: DATA_WIDTH];
        r_id <= w_id;
        r_snap_s <= r_win_s;
        r_snap_e <= r_win_e;
        r_ptr <= (w_id == IW'(NUM_REQ - 1)) ? '0 : w_id + IW'(1);
      end
      if (w_sample) begin
        r_hit <= w_hit;
        r_idx <= w_hit ? bus.cam_search_index_i : '0;
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.cam_search_o = (r_state == ISSUE);
  assign bus.cam_search_data_o = r_key;
  assign bus.cam_start_o = r_snap_s;
  assign bus.cam_end_o = r_snap_e;
  assign bus.rsp_valid_o = (r_state == RESP);
  assign bus.rsp_id_o = r_id;
  assign bus.rsp_hit_o = r_hit;
  assign bus.rsp_index_o = r_idx;
  assign bus.busy_o = (r_state != IDLE);

`ifdef SEARCH_STATS_EN
  logic [STATS_W-1:0] r_hit_cnt, r_miss_cnt;
  logic w_rsp;
  assign w_rsp = (r_state == RESP);
  // a new window restarts the counts but still credits a response in that same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else if (bus.win_valid_i) begin
      r_hit_cnt <= STATS_W'(w_rsp && r_hit);
      r_miss_cnt <= STATS_W'(w_rsp && !r_hit);
    end else begin
      if (w_rsp && r_hit && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + STATS_W'(1);
      if (w_rsp && !r_hit && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + STATS_W'(1);
    end
  end
  assign bus.hit_cnt_o = r_hit_cnt;
  assign bus.miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_cam_search_arb.sv
// tb_cam_search_arb: table vectors, directed corner sequences and random traffic against a timeline model
module tb_cam_search_arb;
  localparam int DW = 32, AW = 5, NR = 4, L = 1, D = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_search_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();
  cam_search_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .CAM_LAT(L)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int ws; int we; int ci; bit cv; logic [NR-1:0] req;
    int e_id; bit e_hit; int e_idx;
  } vec_t;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit s_rst = 1, s_wv = 0, s_hold = 0, s_cv = 0;
  int s_ws = 0, s_we = 0, s_ci = 0;
  logic [NR-1:0] s_req = '0;
  logic [DW-1:0] s_key [NR];
  bit m_wv = 0, m_hit = 0;
  int m_ws = 0, m_we = 0, m_ptr = 0, m_g = -1, m_id = 0, m_ss = 0, m_se = 0, m_idx = 0, m_hc = 0, m_mc = 0;
  logic [DW-1:0] m_key = '0;
  int grants[$];
  bit got_rsp = 0;
  int g_id = 0, g_hit = 0, g_idx = 0;
  logic [NR-1:0] g_ready = '0;

  // window membership as modular distance from the start address
  function automatic bit inwin(int i, int s, int e);
    return ((i - s + D) % D) <= ((e - s + D) % D);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [NR-1:0] er;
    int w;
    bit rv, bz;
    @(posedge clk);
    cyc++;
    #1;
    rst = s_rst;
    bus.req_valid_i = s_req;
    for (int k = 0; k < NR; k++) bus.req_data_i[k*DW +: DW] = s_key[k];
    bus.win_valid_i = s_wv;
    bus.win_start_i = AW'(s_ws);
    bus.win_end_i = AW'(s_we);
    if (m_g >= 0 && cyc == m_g + 1 + L) begin
      bus.cam_search_valid_i = s_cv;
      bus.cam_search_index_i = AW'(s_ci);
      m_hit = s_cv && inwin(s_ci, m_ss, m_se);
      m_idx = m_hit ? s_ci : 0;
    end else begin
      bus.cam_search_valid_i = 1'($urandom);
      bus.cam_search_index_i = AW'($urandom);
    end
    er = '0;
    w = 0;
    if (!s_rst && m_wv && m_g < 0 && s_req != '0) begin
      for (int i = 0; i < NR; i++)
        if (s_req[(m_ptr + i) % NR]) begin w = (m_ptr + i) % NR; break; end
      er[w] = 1'b1;
    end
    rv = m_g >= 0 && cyc == m_g + L + 2;
    bz = m_g >= 0 && cyc > m_g;
    @(negedge clk);
    g_ready = bus.req_ready_o;
    if (cyc > 1) begin
      chk("ready", bus.req_ready_o, er);
      chk("cam_search", bus.cam_search_o, m_g >= 0 && cyc == m_g + 1);
      chk("busy", bus.busy_o, bz);
      chk("rsp_valid", bus.rsp_valid_o, rv);
      if (bz) begin
        chk("cam_data", bus.cam_search_data_o, m_key);
        chk("cam_start", bus.cam_start_o, m_ss);
        chk("cam_end", bus.cam_end_o, m_se);
      end
      if (rv) begin
        chk("rsp_id", bus.rsp_id_o, m_id);
        chk("rsp_hit", bus.rsp_hit_o, m_hit);
        chk("rsp_index", bus.rsp_index_o, m_idx);
        got_rsp = 1;
        g_id = int'(bus.rsp_id_o);
        g_hit = int'(bus.rsp_hit_o);
        g_idx = int'(bus.rsp_index_o);
      end
`ifdef SEARCH_STATS_EN
      chk("hit_cnt", bus.hit_cnt_o, m_hc);
      chk("miss_cnt", bus.miss_cnt_o, m_mc);
`endif
    end
    if (s_wv) begin
      m_hc = (rv && m_hit) ? 1 : 0;
      m_mc = (rv && !m_hit) ? 1 : 0;
    end else if (rv) begin
      if (m_hit && m_hc < 65535) m_hc++;
      if (!m_hit && m_mc < 65535) m_mc++;
    end
    if (rv) m_g = -1;
    if (er != '0) begin
      m_g = cyc; m_id = w; m_key = s_key[w]; m_ss = m_ws; m_se = m_we;
      m_ptr = (w + 1) % NR;
      grants.push_back(w);
      if (!s_hold) s_req[w] = 1'b0;
      s_key[w] = $urandom;
    end
    if (s_wv) begin m_wv = 1; m_ws = s_ws; m_we = s_we; end
    if (s_rst) begin
      m_wv = 0; m_ws = 0; m_we = 0; m_ptr = 0; m_g = -1; m_hc = 0; m_mc = 0;
    end
  endtask

  task automatic do_reset();
    s_rst = 1; s_req = '0; s_wv = 0; s_hold = 0;
    tick();
    tick();
    s_rst = 0;
  endtask

  task automatic load_win(int s, int e);
    s_wv = 1; s_ws = s; s_we = e;
    tick();
    s_wv = 0;
  endtask

  task automatic wait_rsp();
    got_rsp = 0;
    for (int i = 0; i < 30 && !got_rsp; i++) tick();
    if (!got_rsp) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_grant();
    grants.delete();
    for (int i = 0; i < 30 && grants.size() == 0; i++) tick();
    if (grants.size() == 0) begin
      chk("grant_timeout", 0, 1);
      grants.push_back(-1);
    end
  endtask

  vec_t tbl [12];
  int nready;

  initial begin
    for (int k = 0; k < NR; k++) s_key[k] = $urandom;
    bus.req_valid_i = '0; bus.req_data_i = '0; bus.win_valid_i = 0;
    bus.win_start_i = '0; bus.win_end_i = '0;
    bus.cam_search_valid_i = 0; bus.cam_search_index_i = '0;
    tbl[0]  = '{2, 9, 5, 1, 4'b0001, 0, 1, 5};
    tbl[1]  = '{2, 9, 12, 1, 4'b0010, 1, 0, 0};
    tbl[2]  = '{28, 3, 30, 1, 4'b1000, 3, 1, 30};
    tbl[3]  = '{28, 3, 1, 1, 4'b0110, 1, 1, 1};
    tbl[4]  = '{28, 3, 10, 1, 4'b0101, 2, 0, 0};
    tbl[5]  = '{7, 7, 7, 1, 4'b0011, 0, 1, 7};
    tbl[6]  = '{7, 7, 8, 1, 4'b0001, 0, 0, 0};
    tbl[7]  = '{2, 9, 5, 0, 4'b0100, 2, 0, 0};
    tbl[8]  = '{2, 9, 2, 1, 4'b1001, 3, 1, 2};
    tbl[9]  = '{2, 9, 9, 1, 4'b0001, 0, 1, 9};
    tbl[10] = '{2, 9, 1, 1, 4'b0010, 1, 0, 0};
    tbl[11] = '{0, 31, 31, 1, 4'b1111, 2, 1, 31};

    do_reset();
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_rsp", bus.rsp_valid_o, 0);

    // requests without a window must wait
    s_req = 4'b0001; s_cv = 1; s_ci = 5;
    nready = 0;
    repeat (20) begin tick(); if (g_ready != '0) nready++; end
    chk("no_win_ready", nready, 0);
    load_win(2, 9);
    tick();
    chk("grant_after_win", g_ready, 4'b0001);
    wait_rsp();
    chk("first_hit", g_hit, 1);
    chk("first_idx", g_idx, 5);

    // all requesters continuously active
    do_reset();
    load_win(2, 9);
    s_hold = 1; s_req = '1; grants.delete();
    for (int i = 0; i < 100 && grants.size() < 5; i++) tick();
    chk("rr_count", grants.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], i % NR);
    s_hold = 0; s_req = '0;
    repeat (L + 4) tick();

    // reset while waiting on the CAM
    do_reset();
    load_win(2, 9);
    s_req = 4'b0001;
    wait_grant();
    tick();
    s_rst = 1;
    tick();
    s_rst = 0;
    tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_rsp", bus.rsp_valid_o, 0);
    load_win(2, 9);
    s_req = '1;
    wait_grant();
    s_req = '0;
    chk("rst_ptr", grants[0], 0);
    wait_rsp();

    // table-driven hit rule and arbitration vectors
    do_reset();
    foreach (tbl[i]) begin
      load_win(tbl[i].ws, tbl[i].we);
      s_cv = tbl[i].cv; s_ci = tbl[i].ci; s_req = tbl[i].req;
      wait_rsp();
      s_req = '0;
      chk("tbl_id", g_id, tbl[i].e_id);
      chk("tbl_hit", g_hit, tbl[i].e_hit);
      chk("tbl_idx", g_idx, tbl[i].e_idx);
    end

`ifdef SEARCH_STATS_EN
    do_reset();
    load_win(2, 9);
    for (int i = 0; i < 4; i++) begin
      s_cv = 1; s_ci = (i == 3) ? 12 : 3 + i; s_req = 4'b0001;
      wait_rsp();
    end
    tick();
    chk("stats_hits", bus.hit_cnt_o, 3);
    chk("stats_misses", bus.miss_cnt_o, 1);
    load_win(2, 9);
    tick();
    chk("stats_clear", bus.hit_cnt_o + bus.miss_cnt_o, 0);
`endif

    // random traffic against the timeline model
    do_reset();
    load_win(0, 15);
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NR; k++) if (!s_req[k] && $urandom_range(0, 3) == 0) s_req[k] = 1'b1;
      s_wv = ($urandom_range(0, 14) == 0);
      s_ws = $urandom_range(0, D - 1);
      s_we = $urandom_range(0, D - 1);
      s_cv = ($urandom_range(0, 3) != 0);
      s_ci = $urandom_range(0, D - 1);
      s_rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    s_rst = 0; s_wv = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
